// File: rtl/vga_timing_engine_if.sv
// Bundles the run control, pixel colour fetch and video timing outputs of vga_timing_engine.
`default_nettype none

interface vga_timing_engine_if;
  logic        enable;
  logic [11:0] colour_in;
  logic        pattern_sel;
  logic [18:0] address;
  logic        pix_valid;
  logic        hs;
  logic        vs;
  logic [11:0] colour_out;
  logic        end_of_frame;
  logic        ref_pulse;
  logic [15:0] frame_count;

  modport master (
    input  enable, colour_in, pattern_sel,
    output address, pix_valid, hs, vs, colour_out, end_of_frame, ref_pulse, frame_count
  );

  modport slave (
    output enable, colour_in, pattern_sel,
    input  address, pix_valid, hs, vs, colour_out, end_of_frame, ref_pulse, frame_count
  );
endinterface

`default_nettype wire

// File: rtl/vga_timing_engine.sv
// +--------------------------------------------------------------------------+
// | Module  : vga_timing_engine                                              |
// | Brief   : VGA pixel divider, h/v counters, sync/colour pipeline, frame   |
// |           and refresh pulses. Optional colour bars: VGA_TEST_PATTERN_EN. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_timing_engine #(
  parameter int CLK_DIV        = 4,
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter bit SYNC_POL       = 1'b0,
  parameter int REFRESH_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_timing_engine_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [6:0] REF_LAST = 7'(REFRESH_FRAMES - 1);

  logic [3:0]  r_div;
  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic [6:0]  r_ref_cnt;
  logic [15:0] r_frames;
  logic [11:0] r_colour;
  logic        r_hs;
  logic        r_vs;

  logic        w_tick;
  logic        w_line_end;
  logic        w_eof;
  logic        w_ref;
  logic        w_pix_valid;
  logic        w_hs_zone;
  logic        w_vs_zone;
  logic [11:0] w_colour_src;

  // Reset gates the tick so the combinational pulses can never fire during reset.
  assign w_tick      = bus.enable & ~reset & (r_div == DIV_LAST);
  assign w_line_end  = (r_h == H_LAST);
  assign w_eof       = w_tick & w_line_end & (r_v == V_LAST);
  assign w_ref       = w_eof & (r_ref_cnt == REF_LAST);
  assign w_pix_valid = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_zone   = (r_h >= HS_FIRST) && (r_h <= HS_LAST);
  assign w_vs_zone   = (r_v >= VS_FIRST) && (r_v <= VS_LAST);

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  w_bar;
  logic [11:0] w_bar_colour;

  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(r_h) >= k * BAR_W) w_bar = 3'(k);
    end
  end

  always_comb begin
    w_bar_colour = 12'h000;
    case (w_bar)
      3'd0:    w_bar_colour = 12'hFFF;
      3'd1:    w_bar_colour = 12'hFF0;
      3'd2:    w_bar_colour = 12'h0FF;
      3'd3:    w_bar_colour = 12'h0F0;
      3'd4:    w_bar_colour = 12'hF0F;
      3'd5:    w_bar_colour = 12'hF00;
      3'd6:    w_bar_colour = 12'h00F;
      default: w_bar_colour = 12'h000;
    endcase
  end

  assign w_colour_src = bus.pattern_sel ? w_bar_colour : bus.colour_in;
`else
  assign w_colour_src = bus.colour_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div     <= '0;
      r_h       <= '0;
      r_v       <= '0;
      r_ref_cnt <= '0;
      r_frames  <= '0;
      r_colour  <= '0;
      r_hs      <= ~SYNC_POL;
      r_vs      <= ~SYNC_POL;
    end else if (bus.enable) begin
      if (w_tick) begin
        r_div    <= '0;
        r_h      <= w_line_end ? 10'd0 : r_h + 10'd1;
        if (w_line_end) r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
        // Sync and colour share one pixel of latency so they stay aligned.
        r_colour <= w_pix_valid ? w_colour_src : 12'h000;
        r_hs     <= w_hs_zone ? SYNC_POL : ~SYNC_POL;
        r_vs     <= w_vs_zone ? SYNC_POL : ~SYNC_POL;
        if (w_eof) begin
          r_frames  <= r_frames + 16'd1;
          r_ref_cnt <= w_ref ? 7'd0 : r_ref_cnt + 7'd1;
        end
      end else begin
        r_div <= r_div + 4'd1;
      end
    end else begin
      r_colour <= '0;
    end
  end

  assign bus.address      = {r_h, r_v[8:0]};
  assign bus.pix_valid    = w_pix_valid;
  assign bus.hs           = r_hs;
  assign bus.vs           = r_vs;
  assign bus.colour_out   = bus.enable ? r_colour : 12'h000;
  assign bus.end_of_frame = w_eof;
  assign bus.ref_pulse    = w_ref;
  assign bus.frame_count  = r_frames;

endmodule

`default_nettype wire
